// File: rtl/li_pkg.sv
// Shared definitions for latency-insensitive links and shells.
// Provides the link width default and the pointer/count sizing helper.
package li_pkg;

   localparam int unsigned LI_WIDTH_DEFAULT = 6;

   // Bit width needed to index n values, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/li_link.sv
// Latency-insensitive link: sender drives data/valid, receiver drives stop.
// A token moves only in a cycle where valid is high and stop is low.
interface li_link #(
   parameter int unsigned WIDTH = li_pkg::LI_WIDTH_DEFAULT
);

   logic [WIDTH-1:0] data;
   logic             valid;
   logic             stop;

   modport source (
      output data,
      output valid,
      input  stop
   );

   modport sink (
      input  data,
      input  valid,
      output stop
   );

endinterface

// File: rtl/li_shell_queue.sv
// Circular input queue for the shell; any depth from 2 upward, pointers wrap explicitly.
// Storage is deliberately left out of reset; only the bookkeeping registers clear.
module li_shell_queue
   import li_pkg::*;
#(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              push_i,
   input  logic                              pop_i,
   input  logic [WIDTH-1:0]                  din_i,
   output logic [WIDTH-1:0]                  head_o,
   output logic [clog2_min1(DEPTH+1)-1:0]    count_o,
   output logic                              full_o
);

   localparam int unsigned PTR_W = clog2_min1(DEPTH);
   localparam int unsigned CNT_W = clog2_min1(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en;
   logic             pop_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/li_shell.sv
// Latency-insensitive shell around a single-input, single-output pearl.
// Fires the pearl when a token is queued and the downstream link can take the result.
module li_shell
   import li_pkg::*;
#(
   parameter int unsigned WIDTH_IN    = 6,
   parameter int unsigned WIDTH_OUT   = 6,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   li_link.sink                 in_link,
   li_link.source               out_link,
   output logic [WIDTH_IN-1:0]  pearl_in_data,
   output logic                 pearl_enable,
   input  logic [WIDTH_OUT-1:0] pearl_out_data
);

   localparam int unsigned CNT_W = clog2_min1(QUEUE_DEPTH + 1);

   logic [CNT_W-1:0] count;
   logic             full;
   logic             accept;
   logic             fire;
   logic             out_valid_q, out_valid_d;

   // Stop comes from the queue's registered count only, so no path from out_link.stop.
   assign in_link.stop = full;
   assign accept       = in_link.valid & ~full;
   assign fire         = (count != '0) & ~(out_valid_q & out_link.stop);

   li_shell_queue #(
      .WIDTH (WIDTH_IN),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .push_i  (accept),
      .pop_i   (fire),
      .din_i   (in_link.data),
      .head_o  (pearl_in_data),
      .count_o (count),
      .full_o  (full)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      if (fire) begin
         out_valid_d = 1'b1;
      end else if (!out_link.stop) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
      end
   end

   assign pearl_enable   = fire;
   assign out_link.valid = out_valid_q;
   assign out_link.data  = pearl_out_data;

endmodule

// File: tb/tb_li_shell.sv
// Directed bench for li_shell: depth-2 instance for timing/stall/reset, depth-3 for wrap-around.
// Identity pearls register their input on pearl_enable.
module tb_li_shell;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   li_link #(.WIDTH(6)) in2 ();
   li_link #(.WIDTH(6)) out2 ();
   li_link #(.WIDTH(6)) in3 ();
   li_link #(.WIDTH(6)) out3 ();

   logic [5:0] pin2, pout2, pin3, pout3;
   logic       pe2, pe3;

   li_shell #(
      .WIDTH_IN    (6),
      .WIDTH_OUT   (6),
      .QUEUE_DEPTH (2)
   ) u_dut2 (
      .clk            (clk),
      .reset          (reset),
      .in_link        (in2),
      .out_link       (out2),
      .pearl_in_data  (pin2),
      .pearl_enable   (pe2),
      .pearl_out_data (pout2)
   );

   li_shell #(
      .WIDTH_IN    (6),
      .WIDTH_OUT   (6),
      .QUEUE_DEPTH (3)
   ) u_dut3 (
      .clk            (clk),
      .reset          (reset),
      .in_link        (in3),
      .out_link       (out3),
      .pearl_in_data  (pin3),
      .pearl_enable   (pe3),
      .pearl_out_data (pout3)
   );

   always @(posedge clk) begin
      if (pe2) pout2 <= pin2;
      if (pe3) pout3 <= pin3;
   end

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   logic [5:0]  expq [$];
   int unsigned tk;
   int unsigned rcv;
   logic        ev;

   initial begin
      reset      = 1'b0;
      in2.valid  = 1'b0;
      in2.data   = '0;
      out2.stop  = 1'b0;
      in3.valid  = 1'b0;
      in3.data   = '0;
      out3.stop  = 1'b0;

      // reset state
      #2;
      chk("rst_in_stop", in2.stop, 0);
      chk("rst_out_valid", out2.valid, 0);
      chk("rst_pe", pe2, 0);
      chk("rst3_in_stop", in3.stop, 0);
      #10 reset = 1'b1;

      // single token through identity pearl
      step(); in2.valid = 1'b1; in2.data = 6'h2A; settle();
      chk("one_in_stop", in2.stop, 0);
      chk("one_pe_c0", pe2, 0);
      step(); in2.valid = 1'b0; settle();
      chk("one_pe_c1", pe2, 1);
      chk("one_head_c1", pin2, 6'h2A);
      chk("one_valid_c1", out2.valid, 0);
      step(); settle();
      chk("one_valid_c2", out2.valid, 1);
      chk("one_data_c2", out2.data, 6'h2A);
      chk("one_pe_c2", pe2, 0);
      step(); settle();
      chk("one_valid_c3", out2.valid, 0);

      // back-to-back streaming 0x01..0x10
      for (int j = 0; j <= 18; j++) begin
         step();
         if (j < 16) begin
            in2.valid = 1'b1;
            in2.data  = 6'(j + 1);
         end else begin
            in2.valid = 1'b0;
         end
         settle();
         chk("strm_in_stop", in2.stop, 0);
         chk("strm_pe", pe2, (j >= 1 && j <= 16));
         ev = (j >= 2 && j <= 17);
         chk("strm_valid", out2.valid, ev);
         if (ev) chk("strm_data", out2.data, 6'(j - 1));
      end

      // downstream stall for 5 cycles, sender holds while stopped
      tk = 0;
      for (int j = 0; j <= 17; j++) begin
         step();
         in2.valid = (tk < 10);
         in2.data  = 6'(32'h20 + tk);
         out2.stop = (j >= 4 && j <= 8);
         settle();
         chk("stall_in_stop", in2.stop, (j >= 5 && j <= 9));
         chk("stall_pe", pe2, ((j >= 1 && j <= 3) || (j >= 9 && j <= 15)));
         ev = (j >= 2 && j <= 16);
         chk("stall_valid", out2.valid, ev);
         if (ev) begin
            if (j <= 3)      chk("stall_data", out2.data, 6'(32'h20 + j - 2));
            else if (j <= 9) chk("stall_hold", out2.data, 6'h22);
            else             chk("stall_data", out2.data, 6'(32'h20 + j - 7));
         end
         if (in2.valid && !in2.stop) tk++;
      end
      chk("stall_sent", tk, 10);
      out2.stop = 1'b0;

      // reset with two tokens queued and out_valid high
      step(); in2.valid = 1'b1; in2.data = 6'h11; settle();
      step(); in2.data = 6'h12; settle();
      step(); in2.data = 6'h13; out2.stop = 1'b1; settle();
      step(); settle();
      chk("mid_pre_in_stop", in2.stop, 1);
      chk("mid_pre_valid", out2.valid, 1);
      reset = 1'b0;
      #1;
      chk("mid_in_stop", in2.stop, 0);
      chk("mid_valid", out2.valid, 0);
      chk("mid_pe", pe2, 0);
      #2;
      in2.valid = 1'b0;
      out2.stop = 1'b0;
      reset     = 1'b1;
      step(); settle();
      chk("post_valid", out2.valid, 0);
      chk("post_pe", pe2, 0);

      // depth-3 wrap-around under random downstream stop
      tk  = 0;
      rcv = 0;
      for (int c = 0; c < 3000 && rcv < 100; c++) begin
         step();
         in3.valid = (tk < 100);
         in3.data  = 6'(tk * 7 + 3);
         out3.stop = 1'($urandom_range(0, 1));
         settle();
         if (in3.valid && !in3.stop) begin
            expq.push_back(in3.data);
            tk++;
         end
         if (out3.valid && !out3.stop) begin
            if (expq.size() == 0) chk("wrap_extra", 1, 0);
            else                  chk("wrap_data", out3.data, expq.pop_front());
            rcv++;
         end
      end
      chk("wrap_count", rcv, 100);
      in3.valid = 1'b0;
      out3.stop = 1'b0;
      step(); step(); settle();
      chk("wrap_idle_valid", out3.valid, 0);
      chk("wrap_left", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/li_shell.md
# li_shell

Latency-insensitive shell (Carloni protocol) that wraps a single-input, single-output pearl. It sits directly downstream of a relay-station chain: it consumes that chain's `li_link` and buffers tokens in a small input queue. It fires the pearl only when a token is available and the downstream link is not back-pressuring, then drives its own `li_link` into the next relay-station chain.

## Interface
Parameters:
- `WIDTH_IN`, 6: data width of the incoming link and of `pearl_in_data`.
- `WIDTH_OUT`, 6: data width of the outgoing link and of `pearl_out_data`.
- `QUEUE_DEPTH`, 2: input queue entries; legal range 2 to 16.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `in_link`  `li_link.sink`  `WIDTH_IN`  upstream link; shell reads `data`/`valid` and drives `stop`.
- `out_link`  `li_link.source`  `WIDTH_OUT`  downstream link; shell drives `data`/`valid` and reads `stop`.
- `pearl_in_data`  out  `WIDTH_IN`  head-of-queue token presented to the pearl.
- `pearl_enable`  out  1  pearl clock-enable; high exactly in firing cycles.
- `pearl_out_data`  in  `WIDTH_OUT`  pearl result, registered inside the pearl on `pearl_enable`.

## Operation
- Protocol: the sender holds `data`/`valid` while the receiver's `stop` is high.
  - A token transfers in a cycle only when `valid`=1 and `stop`=0.
- Input queue:
  - Circular buffer with `count` from 0 to `QUEUE_DEPTH`.
  - `in_link.stop` = (`count` == `QUEUE_DEPTH`), decoded from registers only; there is no combinational path from `out_link.stop`.
  - `accept` = `in_link.valid` & ~`in_link.stop`.
- Fire condition:
  - `fire` = (`count` != 0) & ~(`out_valid` & `out_link.stop`).
  - `pop` = `fire`.
  - `pearl_enable` = `fire`.
  - `pearl_in_data` = queue head; it is don't-care when empty.
- Simultaneous push and pop: `count` unchanged, both pointers advance. A full queue with a pop still keeps stop high that cycle; this is conservative by design.
- Output valid register `out_valid`:
  - on `fire`: set to 1.
  - else if ~`out_link.stop`: clear to 0.
  - else: hold.
- Outputs: `out_link.valid` = `out_valid`; `out_link.data` = `pearl_out_data`. The pearl holds its output while not enabled, so data is stable during a stall.
- Pointer wrap: a pointer at `QUEUE_DEPTH-1` wraps to 0. Non-power-of-two depths are supported.
- Reset, asynchronous, at any time including mid-transfer:
  - `count`=0, both pointers=0, `out_valid`=0.
  - Consequently `in_link.stop`=0 and `pearl_enable`=0.
  - Queue contents are not reset.
  - Tokens in flight are discarded.

## Timing
- Latency:
  - Token accepted at edge t: it is at the head in cycle t+1 and fires in t+1 if not stalled.
  - `out_link.valid` rises in cycle t+2, with `pearl_out_data` valid in the same cycle.
- Throughput: 1 token/cycle sustained with no downstream stop. Queue occupancy settles at 1.
- Back-pressure:
  - `out_link.stop` high while `out_valid`=1 blocks fire in that same cycle.
  - The queue fills within `QUEUE_DEPTH` cycles.
  - `in_link.stop` rises the cycle after `count` reaches `QUEUE_DEPTH`.
- Stop release: after `out_link.stop` falls, `fire` resumes in that same cycle if the queue is non-empty.

## Structure
- Shared package `li_pkg`:
  - the `li_link` interface parameter conventions;
  - the function `clog2_min1(n)`, used for pointer/count widths.
- Sub-module `li_shell_queue`: circular FIFO with push, pop, head, count and full.
  - The shell adds only the fire logic and `out_valid`.
- No per-pearl logic in the shell; pearls attach through the `pearl_*` ports.

## Test plan
- Reset mid-stream: queue holding 2 tokens, `out_valid`=1, assert `reset`=0 -> immediately `count`=0, `out_link.valid`=0, `in_link.stop`=0, `pearl_enable`=0.
- Single token, identity pearl: token 0x2A with valid at edge 0 -> `pearl_enable`=1 in cycle 1; `out_link.valid`=1 with `data`=0x2A in cycle 2, then 0 in cycle 3.
- Streaming: 0x01..0x10 back-to-back, `out_link.stop`=0 -> identical sequence out, one per cycle; `in_link.stop` never asserted.
- Downstream stall: `out_link.stop`=1 for 5 cycles during streaming (`QUEUE_DEPTH`=2) ->
  - `out_link.data` held constant;
  - `in_link.stop`=1 from the cycle after the queue fills;
  - no token lost or duplicated after release.
- Full with simultaneous pop: queue full, stop released -> `in_link.stop` stays high one cycle, then drops; the upstream held token is accepted exactly once.
- Wrap-around, `QUEUE_DEPTH`=3: 100 tokens under random `out_link.stop` (50%) -> output sequence equals input sequence in order, compared with a scoreboard.
